u409_tack_engine: RTL and testbench



---
 rtl/u409_tack_engine_if.sv | 31 +++
 rtl/u409_tack_engine.sv | 195 +++++++++++++++++++
 tb/tb_u409_tack_engine.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/u409_tack_engine_if.sv
// u409_tack_engine_if: 68040 transfer-acknowledge bus bundle between the
// address decode side (master) and the TACK engine (slave).
interface u409_tack_engine_if #(
  parameter int NUM_CH = 4,
  parameter int WS_W   = 4
);

  logic                   TSn;
  logic                   LINE;
  logic [NUM_CH-1:0]      SPACE_SEL;
  logic [NUM_CH*WS_W-1:0] WAIT_CFG;
  logic [NUM_CH-1:0]      BURST_OK;
  logic [NUM_CH-1:0]      EXT_MODE;
  logic [NUM_CH-1:0]      EXT_ACK;
  logic                   TACK_OUT;
  logic                   TACK_OE;
  logic                   TBIn;
  logic                   TEAn;
  logic                   BUSY;

  modport master (
    output TSn, LINE, SPACE_SEL, WAIT_CFG, BURST_OK, EXT_MODE, EXT_ACK,
    input  TACK_OUT, TACK_OE, TBIn, TEAn, BUSY
  );

  modport slave (
    input  TSn, LINE, SPACE_SEL, WAIT_CFG, BURST_OK, EXT_MODE, EXT_ACK,
    output TACK_OUT, TACK_OE, TBIn, TEAn, BUSY
  );

endinterface

// File: rtl/u409_tack_engine.sv
// u409_tack_engine: transfer-acknowledge generator for the 68040 local bus.
// Produces TACKn drive/enable, TBIn and TEAn from one-hot space selects and
// per-channel wait/burst/external-ack configuration. The TACKn pad itself
// lives in the top level.
// Optional: define TACK_TIMEOUT_EN to build the external-ack bus-error
// timeout (TEAn after TO_CYCLES WAIT cycles); otherwise TEAn is tied high.
module u409_tack_engine #(
  parameter int NUM_CH    = 4,
  parameter int WS_W      = 4,
  parameter int TO_W      = 8,
  parameter int TO_CYCLES = 200
) (
  input  logic               CLK40,
  input  logic               RESET,
  u409_tack_engine_if.slave  bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_ACK     = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_TOUT    = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [WS_W-1:0] w_q, w_d;
  logic [WS_W-1:0] cnt_q, cnt_d;
  logic [1:0]      beats_q, beats_d;
  logic            ext_q, ext_d;
  logic            inhibit_q, inhibit_d;
  logic            first_q, first_d;

  logic            start;
  logic [CH_W-1:0] sel_ch;
  logic [WS_W-1:0] sel_w;
  logic            sel_bok;
  logic            sel_ext;

  logic            tack_out_q;
  logic            tack_oe_q;
  logic            tbi_n_q;
  logic            busy_q;

`ifdef TACK_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            tea_n_q;
`endif

  assign start = !bus.TSn && (|bus.SPACE_SEL);

  // Lowest-index selected channel wins; capture its configuration fields.
  always_comb begin
    sel_ch  = '0;
    sel_w   = '0;
    sel_bok = 1'b0;
    sel_ext = 1'b0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (bus.SPACE_SEL[i-1]) begin
        sel_ch  = CH_W'(i - 1);
        sel_w   = bus.WAIT_CFG[(i-1)*WS_W +: WS_W];
        sel_bok = bus.BURST_OK[i-1];
        sel_ext = bus.EXT_MODE[i-1];
      end
    end
  end

  // Next-state and datapath update for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    w_d       = w_q;
    cnt_d     = cnt_q;
    beats_d   = beats_q;
    ext_d     = ext_q;
    inhibit_d = inhibit_q;
    first_d   = first_q;
`ifdef TACK_TIMEOUT_EN
    to_d      = to_q;
`endif
    case (state_q)
      S_IDLE, S_RELEASE: begin
        if (start) begin
          state_d   = S_WAIT;
          ch_d      = sel_ch;
          w_d       = sel_w;
          cnt_d     = sel_w;
          ext_d     = sel_ext;
          // External channels never burst, so a line request to them is inhibited.
          beats_d   = (bus.LINE && sel_bok && !sel_ext) ? 2'd3 : 2'd0;
          inhibit_d = bus.LINE && !(sel_bok && !sel_ext);
          first_d   = 1'b1;
`ifdef TACK_TIMEOUT_EN
          to_d      = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (ext_q) begin
          if (bus.EXT_ACK[ch_q]) begin
            state_d = S_ACK;
          end
`ifdef TACK_TIMEOUT_EN
          else if (to_q == TO_LAST) begin
            state_d = S_TOUT;
          end else begin
            to_d = to_q + 1'b1;
          end
`endif
        end else if (cnt_q == '0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACK: begin
        first_d = 1'b0;
        if (beats_q != 2'd0) begin
          beats_d = beats_q - 2'd1;
          // The ACK cycle counts as the first of the W inter-beat cycles,
          // so the reload is W-1 to keep beat spacing at W+1 edges.
          if (w_q == '0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = w_q - 1'b1;
          end
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_TOUT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, with outputs registered from the next state so they
  // change cleanly on the clock edge.
  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      w_q        <= '0;
      cnt_q      <= '0;
      beats_q    <= '0;
      ext_q      <= 1'b0;
      inhibit_q  <= 1'b0;
      first_q    <= 1'b0;
      tack_out_q <= 1'b1;
      tack_oe_q  <= 1'b0;
      tbi_n_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      w_q        <= w_d;
      cnt_q      <= cnt_d;
      beats_q    <= beats_d;
      ext_q      <= ext_d;
      inhibit_q  <= inhibit_d;
      first_q    <= first_d;
      tack_out_q <= (state_d != S_ACK);
      tack_oe_q  <= (state_d == S_ACK) || (state_d == S_RELEASE);
      tbi_n_q    <= !((state_d == S_ACK) && first_d && inhibit_d);
      busy_q     <= (state_d != S_IDLE);
    end
  end

`ifdef TACK_TIMEOUT_EN
  // Timeout counter and registered TEAn.
  always_ff @(posedge CLK40) begin
    if (RESET) begin
      to_q    <= '0;
      tea_n_q <= 1'b1;
    end else begin
      to_q    <= to_d;
      tea_n_q <= (state_d != S_TOUT);
    end
  end

  assign bus.TEAn = tea_n_q;
`else
  assign bus.TEAn = 1'b1;
`endif

  assign bus.TACK_OUT = tack_out_q;
  assign bus.TACK_OE  = tack_oe_q;
  assign bus.TBIn     = tbi_n_q;
  assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_u409_tack_engine.sv
// tb_u409_tack_engine: directed bench for u409_tack_engine. Expected TACK
// beats (edge number and TBIn) are queued when a transfer is started and
// checked by a negedge monitor; state-level checks are made inline.
// Timeout checks follow TACK_TIMEOUT_EN.
module tb_u409_tack_engine;

  typedef struct {
    int   edge_no;
    logic tbi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t cur;

  u409_tack_engine_if #(.NUM_CH(4), .WS_W(4)) bus ();

  u409_tack_engine #(
    .NUM_CH(4),
    .WS_W(4),
    .TO_W(8),
    .TO_CYCLES(200)
  ) dut (
    .CLK40(clk),
    .RESET(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  task automatic goto(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  // Drive one TS cycle; k is the edge that samples it. Queues nbeats TACKs.
  task automatic start(input logic [3:0] sel, input logic line, input int w,
                       input int nbeats, input logic tbi, output int k);
    exp_t e;
    #1;
    bus.TSn       = 1'b0;
    bus.SPACE_SEL = sel;
    bus.LINE      = line;
    k = edge_cnt + 1;
    for (int n = 0; n < nbeats; n++) begin
      e.edge_no = k + 1 + w + n * (w + 1);
      e.tbi     = tbi;
      sb.push_back(e);
    end
    @(negedge clk);
    #1;
    bus.TSn       = 1'b1;
    bus.SPACE_SEL = '0;
    bus.LINE      = 1'b0;
  endtask

  task automatic push_exp(input int edge_no, input logic tbi);
    exp_t e;
    e.edge_no = edge_no;
    e.tbi     = tbi;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every TACK-low cycle must match the next queued beat.
  always @(negedge clk) begin
    if (!rst && bus.TACK_OE === 1'b1 && bus.TACK_OUT === 1'b0) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL tack_unexpected: observed TACK at edge %0d expected none", edge_cnt);
      end
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        vectors++;
        assert (edge_cnt === cur.edge_no) else begin
          miscompares++;
          $error("FAIL tack_edge: observed %0d expected %0d", edge_cnt, cur.edge_no);
        end
        vectors++;
        assert (bus.TBIn === cur.tbi) else begin
          miscompares++;
          $error("FAIL tack_tbi: observed %0b expected %0b (edge %0d)", bus.TBIn, cur.tbi, edge_cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    bus.TSn       = 1'b1;
    bus.LINE      = 1'b0;
    bus.SPACE_SEL = '0;
    bus.WAIT_CFG  = 16'h0130;  // W3=0 W2=1 W1=3 W0=0
    bus.BURST_OK  = '0;
    bus.EXT_MODE  = '0;
    bus.EXT_ACK   = '0;

    // Reset and ignored TS with no select
    goto(2);
    chk("rst_tack_out", bus.TACK_OUT, 1);
    chk("rst_tack_oe", bus.TACK_OE, 0);
    chk("rst_tbi", bus.TBIn, 1);
    chk("rst_tea", bus.TEAn, 1);
    chk("rst_busy", bus.BUSY, 0);
    #1 rst = 1'b0;
    bus.TSn = 1'b0;
    goto(4);
    chk("nosel_busy", bus.BUSY, 0);
    chk("nosel_oe", bus.TACK_OE, 0);
    chk("nosel_tack", bus.TACK_OUT, 1);
    #1 bus.TSn = 1'b1;

    // Zero-wait single transfer
    start(4'b0001, 1'b0, 0, 1, 1'b1, k);
    chk("zw_busy_k", bus.BUSY, 1);
    goto(k + 1);
    chk("zw_oe_k1", bus.TACK_OE, 1);
    chk("zw_out_k1", bus.TACK_OUT, 0);
    goto(k + 2);
    chk("zw_oe_k2", bus.TACK_OE, 1);
    chk("zw_out_k2", bus.TACK_OUT, 1);
    goto(k + 3);
    chk("zw_oe_k3", bus.TACK_OE, 0);
    chk("zw_busy_k3", bus.BUSY, 0);

    // Back-to-back: TS sampled during RELEASE
    start(4'b0001, 1'b0, 0, 1, 1'b1, k);
    goto(k + 2);
    start(4'b0001, 1'b0, 0, 1, 1'b1, k);
    chk("b2b_busy", bus.BUSY, 1);
    chk("b2b_oe", bus.TACK_OE, 0);
    goto(k + 3);
    chk("b2b_idle", bus.BUSY, 0);

    // Priority: ch1 (W=3) beats ch2 (W=0 would not apply, ch2 W=1)
    start(4'b0110, 1'b0, 3, 1, 1'b1, k);
    goto(k + 3);
    chk("prio_not_early", bus.TACK_OE, 0);
    goto(k + 6);
    chk("prio_idle", bus.BUSY, 0);

    // Line burst on ch2, W=1
    bus.BURST_OK = 4'b0100;
    start(4'b0100, 1'b1, 1, 4, 1'b1, k);
    goto(k + 3);
    chk("burst_gap_tbi", bus.TBIn, 1);
    chk("burst_gap_oe", bus.TACK_OE, 0);
    goto(k + 10);
    chk("burst_idle", bus.BUSY, 0);

    // Line request without burst support: one beat, TBIn asserted
    bus.BURST_OK = 4'b0000;
    start(4'b0100, 1'b1, 1, 1, 1'b0, k);
    goto(k + 3);
    chk("nob_rel_tbi", bus.TBIn, 1);
    goto(k + 4);

    // Zero-wait burst: four consecutive beats
    bus.BURST_OK = 4'b0001;
    start(4'b0001, 1'b1, 0, 4, 1'b1, k);
    goto(k + 5);
    chk("zwb_release", bus.TACK_OUT, 1);
    chk("zwb_release_oe", bus.TACK_OE, 1);
    goto(k + 6);

    // External ack on ch3 (line request, burst never taken)
    bus.BURST_OK = 4'b1000;
    bus.EXT_MODE = 4'b1000;
    start(4'b1000, 1'b1, 0, 0, 1'b1, k);
    push_exp(k + 10, 1'b0);
    goto(k + 4);
    #1 bus.EXT_ACK = 4'b0001;
    goto(k + 5);
    #1 bus.EXT_ACK = 4'b0000;
    chk("ext_other_ignored", bus.BUSY, 1);
    goto(k + 9);
    #1 bus.EXT_ACK = 4'b1000;
    goto(k + 10);
    #1 bus.EXT_ACK = 4'b0000;
    goto(k + 12);
    chk("ext_idle", bus.BUSY, 0);
    bus.BURST_OK = 4'b0000;

    // No external ack
    start(4'b1000, 1'b0, 0, 0, 1'b1, k);
`ifdef TACK_TIMEOUT_EN
    goto(k + 199);
    chk("to_tea_pre", bus.TEAn, 1);
    chk("to_busy_pre", bus.BUSY, 1);
    goto(k + 200);
    chk("to_tea", bus.TEAn, 0);
    chk("to_oe", bus.TACK_OE, 0);
    goto(k + 201);
    chk("to_tea_post", bus.TEAn, 1);
    chk("to_busy_post", bus.BUSY, 0);
    // EXT_ACK coincident with the limit wins
    start(4'b1000, 1'b0, 0, 0, 1'b1, k);
    push_exp(k + 200, 1'b1);
    goto(k + 199);
    #1 bus.EXT_ACK = 4'b1000;
    goto(k + 200);
    #1 bus.EXT_ACK = 4'b0000;
    chk("race_tea", bus.TEAn, 1);
    goto(k + 202);
    chk("race_idle", bus.BUSY, 0);
`else
    goto(k + 200);
    chk("hang_tea", bus.TEAn, 1);
    goto(k + 300);
    chk("hang_busy", bus.BUSY, 1);
    chk("hang_oe", bus.TACK_OE, 0);
    #1 rst = 1'b1;
    goto(k + 301);
    chk("hang_rst_busy", bus.BUSY, 0);
    #1 rst = 1'b0;
`endif
    bus.EXT_MODE = 4'b0000;

    // Reset during the second beat of a burst
    bus.BURST_OK = 4'b0100;
    start(4'b0100, 1'b1, 1, 4, 1'b1, k);
    goto(k + 4);
    #1 rst = 1'b1;
    sb.delete();
    goto(k + 5);
    chk("mid_rst_out", bus.TACK_OUT, 1);
    chk("mid_rst_oe", bus.TACK_OE, 0);
    chk("mid_rst_tbi", bus.TBIn, 1);
    chk("mid_rst_tea", bus.TEAn, 1);
    chk("mid_rst_busy", bus.BUSY, 0);
    #1 rst = 1'b0;
    goto(k + 6);
    start(4'b0001, 1'b0, 0, 1, 1'b1, k);
    goto(k + 3);
    chk("post_rst_idle", bus.BUSY, 0);
    chk("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
